bus_hs_mux: RTL and testbench
=============================

Name: bus_hs_mux

Overview:
- Parametrised successor to the single-master, single-slave combinational data bus in the single-cycle core.
- Connects one master (core load/store path or future multi-cycle core) to SLV_NUM memory-mapped slaves (RAM, UART, timer, ...).
- Uses a registered valid/ready handshake, address-range decode, wait-state support and a decode-error response.
- Sits between the core's MEM stage and the slave devices.

Parameters:
- CPU_WIDTH, 32, address/data width in bits.
- SLV_NUM, 4, number of slave ports; must be >= 2.
- SEL_LSB, 28, lowest address bit of the slave-select field. The field is addr[SEL_LSB +: SEL_W], with SEL_W = clog2(SLV_NUM) as a localparam.
- TIMEOUT, 16, maximum ACCESS cycles before an error response (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mas_valid  in  1  master request valid.
- mas_we  in  1  1 = write, 0 = read.
- mas_addr  in  CPU_WIDTH  byte address.
- mas_wdata  in  CPU_WIDTH  write data.
- mas_ready  out  1  one-cycle response strobe.
- mas_rdata  out  CPU_WIDTH  read data, valid when mas_ready=1.
- mas_err  out  1  error flag, valid when mas_ready=1.
- slv_valid  out  SLV_NUM  one-hot request to the selected slave.
- slv_we  out  1  shared write enable.
- slv_addr  out  CPU_WIDTH  shared address, the latched master address.
- slv_wdata  out  CPU_WIDTH  shared write data.
- slv_ready  in  SLV_NUM  per-slave completion.
- slv_rdata  in  SLV_NUM*CPU_WIDTH  packed read data; slave i occupies bits [i*CPU_WIDTH +: CPU_WIDTH].

Behaviour:
- Clocking and reset: single clock domain, asynchronous active-low reset (rst_n).
- Reset values: state=IDLE; mas_ready=0; mas_rdata=0; mas_err=0; slv_valid=0; slv_we=0; slv_addr=0; slv_wdata=0; internal index, timeout counter and latches = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately. No response is ever produced for it.
- State IDLE:
  - If mas_valid=1: latch mas_we, mas_addr, mas_wdata; compute idx = mas_addr[SEL_LSB +: SEL_W].
  - If idx < SLV_NUM, go to ACCESS.
  - Otherwise go to RESP with err=1 and rdata=0.
  - mas_valid=0 keeps the block in IDLE.
- State ACCESS:
  - slv_valid[idx]=1, all other bits 0; slv_we, slv_addr and slv_wdata hold the latched values.
  - When slv_ready[idx]=1: capture slv_rdata slice idx (writes capture 0), set err=0, go to RESP.
  - Non-selected slv_ready bits are ignored.
  - The slave may insert any number of wait states.
- State RESP:
  - mas_ready=1 for exactly one cycle, with registered mas_rdata/mas_err; slv_valid=0.
  - Next state is IDLE.
  - mas_rdata/mas_err hold their values after RESP until the next RESP.
- Latency: the request sampled in IDLE at edge N reaches ACCESS at N+1. A zero-wait slave gives mas_ready=1 in cycle N+2. Each slave wait state adds one cycle.
- Master rule: hold mas_valid/mas_addr/mas_we/mas_wdata stable until mas_ready, and deassert mas_valid in the cycle after. If mas_valid is still 1 in IDLE, it is treated as a new request (back-to-back accesses, one every 3 cycles minimum).
- Changes to master inputs after the IDLE sample have no effect on the current transaction.
- SLV_NUM not a power of two: indices SLV_NUM..2^SEL_W-1 produce a decode error.
- Address bits outside the select field pass through to slaves unmodified.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 8-bit-minimum counter clears on entry to ACCESS and increments each ACCESS cycle without slv_ready[idx].
  - When the count reaches TIMEOUT-1 with no ready, the next state is RESP with err=1, rdata=0, and slv_valid drops.
  - slv_ready arriving in the same cycle as expiry wins: normal response, err=0.
- Not defined: no counter is present, and ACCESS waits indefinitely for slv_ready.

Test Plan:
1. Reset: hold rst_n=0 with mas_valid=1 -> all outputs 0 and state IDLE; release -> first request begins.
2. Write: mas_valid=1, we=1, addr=0x1000_0040, wdata=0xDEAD_BEEF, slave1 ready immediately -> slv_valid=4'b0010 in cycle 1; mas_ready=1, err=0 in cycle 2.
3. Read with waits: addr=0x0000_0010, slave0 asserts ready after 3 wait cycles with rdata=0x1234_5678 -> mas_ready at cycle 5, mas_rdata=0x1234_5678, err=0.
4. Decode error: SLV_NUM=3, addr=0x3000_0000 -> no slv_valid bit set; mas_ready=1, err=1, rdata=0 at cycle 1.
5. Timeout (BUS_TIMEOUT_EN, TIMEOUT=16): slave2 never ready -> slv_valid[2] high for 16 cycles, then mas_ready=1, err=1. Without the macro, mas_ready stays 0.
6. Reset mid-ACCESS, then back-to-back: pulse rst_n low during a wait state -> slv_valid=0 and no mas_ready. Then keep mas_valid high across responses -> one response every 3 cycles with zero-wait slaves.

Source files
------------

// File: rtl/bus_hs_mux.sv
// Single-master to SLV_NUM-slave bus with registered valid/ready handshake and address decode.
// Optional: define BUS_TIMEOUT_EN to answer with an error once a slave stalls for TIMEOUT cycles.
module bus_hs_mux #(
    parameter int CPU_WIDTH = 32,
    parameter int SLV_NUM   = 4,
    parameter int SEL_LSB   = 28,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mas_valid,
    input  logic                         mas_we,
    input  logic [CPU_WIDTH-1:0]         mas_addr,
    input  logic [CPU_WIDTH-1:0]         mas_wdata,
    output logic                         mas_ready,
    output logic [CPU_WIDTH-1:0]         mas_rdata,
    output logic                         mas_err,
    output logic [SLV_NUM-1:0]           slv_valid,
    output logic                         slv_we,
    output logic [CPU_WIDTH-1:0]         slv_addr,
    output logic [CPU_WIDTH-1:0]         slv_wdata,
    input  logic [SLV_NUM-1:0]           slv_ready,
    input  logic [SLV_NUM*CPU_WIDTH-1:0] slv_rdata
);

    localparam int SEL_W = $clog2(SLV_NUM);
    localparam logic [SEL_W:0]     SLV_LIMIT = (SEL_W+1)'(SLV_NUM);
    localparam logic [SLV_NUM-1:0] ONE_HOT0  = SLV_NUM'(1);

    if (SLV_NUM < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("bus_hs_mux: SLV_NUM must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state;
    logic [SEL_W-1:0]     idx;
    logic [SEL_W-1:0]     req_idx;
    logic                 req_ok;
    logic                 sel_ready;
    logic [CPU_WIDTH-1:0] sel_rdata;
    logic                 expired;

    assign req_idx = mas_addr[SEL_LSB +: SEL_W];
    assign req_ok  = {1'b0, req_idx} < SLV_LIMIT;

    // Only the latched slave's ready/rdata matter; stray ready bits from others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (idx == SEL_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[i*CPU_WIDTH +: CPU_WIDTH];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) + 1 > 8) ? ($clog2(TIMEOUT) + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign expired = (wait_cnt == CNT_LAST);

    // Counter is zero whenever ACCESS is entered; it only advances on stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!sel_ready && !expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            mas_ready <= 1'b0;
            mas_rdata <= '0;
            mas_err   <= 1'b0;
            slv_valid <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
        end else begin
            mas_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mas_valid) begin
                        slv_we    <= mas_we;
                        slv_addr  <= mas_addr;
                        slv_wdata <= mas_wdata;
                        idx       <= req_idx;
                        if (req_ok) begin
                            slv_valid <= ONE_HOT0 << req_idx;
                            state     <= ACCESS;
                        end else begin
                            mas_rdata <= '0;
                            mas_err   <= 1'b1;
                            mas_ready <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // A ready in the expiry cycle takes priority over the timeout.
                    if (sel_ready) begin
                        mas_rdata <= slv_we ? '0 : sel_rdata;
                        mas_err   <= 1'b0;
                        mas_ready <= 1'b1;
                        slv_valid <= '0;
                        state     <= RESP;
                    end else if (expired) begin
                        mas_rdata <= '0;
                        mas_err   <= 1'b1;
                        mas_ready <= 1'b1;
                        slv_valid <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_hs_mux.sv
// Randomized bench for bus_hs_mux (3 slaves, so select value 3 is a decode error).
// Expectations come from a transaction-level model: latency, response data and error flag.
module tb_bus_hs_mux;

    localparam int CW  = 32;
    localparam int NS  = 3;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mas_valid;
    logic            mas_we;
    logic [CW-1:0]   mas_addr;
    logic [CW-1:0]   mas_wdata;
    logic            mas_ready;
    logic [CW-1:0]   mas_rdata;
    logic            mas_err;
    logic [NS-1:0]   slv_valid;
    logic            slv_we;
    logic [CW-1:0]   slv_addr;
    logic [CW-1:0]   slv_wdata;
    logic [NS-1:0]   slv_ready;
    logic [NS*CW-1:0] slv_rdata;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_resp_cyc = 0;
    logic [CW-1:0] slave_data [NS];
    logic [CW-1:0] last_rdata;
    logic          last_err;

    bus_hs_mux #(.CPU_WIDTH(CW), .SLV_NUM(NS), .SEL_LSB(28), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mas_valid (mas_valid),
        .mas_we    (mas_we),
        .mas_addr  (mas_addr),
        .mas_wdata (mas_wdata),
        .mas_ready (mas_ready),
        .mas_rdata (mas_rdata),
        .mas_err   (mas_err),
        .slv_valid (slv_valid),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_ready (slv_ready),
        .slv_rdata (slv_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One master transaction with a slave that answers after 'waits' stall cycles.
    // Must be called at a negedge where the DUT will be in IDLE at the next posedge.
    task automatic applyStimulus(input logic we, input logic [CW-1:0] addr, input logic [CW-1:0] wdata,
                                 input int waits, input logic [CW-1:0] rdata_sel);
        int            sel;
        int            lat;
        bit            decode_err;
        bit            exp_err;
        bit            done;
        logic [CW-1:0] exp_rdata;
        logic [NS-1:0] exp_valid;
        logic [CW-1:0] lat_addr;
        logic [CW-1:0] lat_wdata;

        sel = int'(addr[29:28]);
        for (int i = 0; i < NS; i++) slave_data[i] = $urandom;
        decode_err = (sel >= NS);
        if (!decode_err) slave_data[sel] = rdata_sel;
        slv_rdata = {slave_data[2], slave_data[1], slave_data[0]};

        exp_err   = decode_err;
        lat       = decode_err ? 1 : waits + 2;
        exp_valid = decode_err ? '0 : NS'(1 << sel);
`ifdef BUS_TIMEOUT_EN
        if (!decode_err && waits >= TO) begin
            exp_err = 1'b1;
            lat     = TO + 1;
        end
`endif
        if (exp_err || we) exp_rdata = '0;
        else               exp_rdata = slave_data[sel];

        lat_addr  = addr;
        lat_wdata = wdata;
        mas_valid = 1'b1;
        mas_we    = we;
        mas_addr  = addr;
        mas_wdata = wdata;
        slv_ready = NS'($urandom) & ~exp_valid;

        done = 1'b0;
        for (int k = 1; k <= lat + 3 && !done; k++) begin
            @(negedge clk);
            if (mas_ready) begin
                checkOutput("resp_cycle", 64'(k), 64'(lat));
                checkOutput("rdata", mas_rdata, exp_rdata);
                checkOutput("err", mas_err, exp_err);
                checkOutput("valid_in_resp", slv_valid, '0);
                last_rdata    = exp_rdata;
                last_err      = exp_err;
                last_resp_cyc = cyc;
                done          = 1'b1;
            end else begin
                checkOutput("slv_valid", slv_valid, exp_valid);
                if (k == 1 && !decode_err) begin
                    checkOutput("slv_addr", slv_addr, lat_addr);
                    checkOutput("slv_we", slv_we, we);
                    checkOutput("slv_wdata", slv_wdata, lat_wdata);
                end
                mas_we    = 1'($urandom);
                mas_addr  = $urandom;
                mas_wdata = $urandom;
                slv_ready = NS'($urandom) & ~exp_valid;
                if (k == waits + 1) slv_ready = slv_ready | exp_valid;
            end
        end
        if (!done) checkOutput("resp_missing", 64'(0), 64'(1));
        slv_ready = '0;
    endtask

    // Advance past the response cycle; 'keep' leaves mas_valid high for back-to-back use.
    task automatic nextCycle(input bit keep);
        if (!keep) mas_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_pulse", mas_ready, 1'b0);
        checkOutput("rdata_hold", mas_rdata, last_rdata);
        checkOutput("err_hold", mas_err, last_err);
        if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   prev;
        bit   keep;
        int   stall;

        rst_n      = 1'b0;
        mas_valid  = 1'b1;
        mas_we     = 1'b1;
        mas_addr   = 32'h1000_0040;
        mas_wdata  = 32'hDEAD_BEEF;
        slv_ready  = '0;
        slv_rdata  = '0;
        last_rdata = '0;
        last_err   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", mas_ready, 1'b0);
        checkOutput("rst_rdata", mas_rdata, '0);
        checkOutput("rst_err", mas_err, 1'b0);
        checkOutput("rst_valid", slv_valid, '0);
        checkOutput("rst_we", slv_we, 1'b0);
        checkOutput("rst_addr", slv_addr, '0);
        checkOutput("rst_wdata", slv_wdata, '0);

        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 0, 32'h0);
        nextCycle(1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678);
        nextCycle(1'b0);
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 0, 32'h0);
`ifdef BUS_TIMEOUT_EN
        nextCycle(1'b0);
        applyStimulus(1'b0, 32'h2000_0008, 32'h0, TO - 1, $urandom);
        nextCycle(1'b0);
        applyStimulus(1'b0, 32'h2000_000C, 32'h0, TO, $urandom);
`endif

        for (int n = 0; n < 25; n++) begin
            keep = 1'($urandom);
            nextCycle(keep);
            applyStimulus(1'($urandom), {2'b00, 2'($urandom), 28'($urandom)}, $urandom,
                          $urandom_range(0, 4), $urandom);
        end

        for (int n = 0; n < 4; n++) begin
            prev = last_resp_cyc;
            nextCycle(1'b1);
            applyStimulus(1'($urandom), {2'b00, 2'($urandom_range(0, 2)), 28'($urandom)}, $urandom,
                          0, $urandom);
            if (n > 0) checkOutput("b2b_spacing", 64'(last_resp_cyc - prev), 64'(3));
        end

        // Slave 2 never answers; without the timeout the bus must stall silently.
        nextCycle(1'b0);
`ifdef BUS_TIMEOUT_EN
        stall = 5;
`else
        stall = 20;
`endif
        mas_valid = 1'b1;
        mas_we    = 1'b0;
        mas_addr  = 32'h2000_0100;
        slv_ready = '0;
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", slv_valid, 3'b100);
            checkOutput("stall_ready", mas_ready, 1'b0);
        end
        rst_n     = 1'b0;
        mas_valid = 1'b0;
        #1;
        checkOutput("midrst_valid", slv_valid, '0);
        checkOutput("midrst_ready", mas_ready, 1'b0);
        checkOutput("midrst_rdata", mas_rdata, '0);
        @(negedge clk);
        rst_n      = 1'b1;
        last_rdata = '0;
        last_err   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_rst_ready", mas_ready, 1'b0);
            checkOutput("post_rst_valid", slv_valid, '0);
        end
        applyStimulus(1'b0, 32'h1000_0200, 32'h0, 1, 32'hCAFE_F00D);
        nextCycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
